if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/pc_reg.sv | 22 ++
 rtl/if_fetch.sv | 88 ++++++++
 tb/tb_if_fetch.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared state encodings and reset constants for the fetch stage
package if_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

  // Word address 0x0C00 is byte address 0x0000_3000.
  localparam logic [29:0] DEFAULT_RESET_PC = 30'h0000_0C00;

  function automatic logic [31:0] cnt_inc(input logic [31:0] c);
    return c + 32'd1;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - 30-bit word program counter with load enable
module pc_reg
  import if_fetch_pkg::*;
#(
  parameter logic [29:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [29:0] d,
  output logic [29:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - single-outstanding instruction fetch stage with one-entry output buffer
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:2] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:2] pc,
  input  logic [31:2] npc,
  output logic        im_req,
  output logic [31:2] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:2] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] fetch_cnt
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic         accept;
  logic         capture;

  // Handshakes are qualified by the registered state, never by the peer's input.
  assign capture = im_req & im_ack;
  assign accept  = inst_valid & inst_ready;
  assign im_addr = pc;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .d    (npc),
    .q    (pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   if (im_ack) state_nxt = S_FULL;
      S_FULL:  if (inst_ready) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    im_req     = 1'b0;
    inst_valid = 1'b0;
    case (state)
      S_REQ:   im_req = 1'b1;
      S_FULL:  inst_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst    <= 32'd0;
      inst_pc <= 30'd0;
    end else if (capture) begin
      inst    <= im_rdata;
      inst_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= 32'd0;
    end else if (accept) begin
      fetch_cnt <= cnt_inc(fetch_cnt);
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - scoreboard bench for the fetch stage against a transaction-level model
module tb_if_fetch;

  localparam logic [29:0] RST_PC = 30'h0000_0C00;

  logic        clk;
  logic        rst;
  logic [29:0] pc;
  logic [29:0] npc;
  logic        im_req;
  logic [29:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [29:0] inst_pc;
  logic        inst_ready;
  logic [31:0] fetch_cnt;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .npc        (npc),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_ack     (im_ack),
    .im_rdata   (im_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .fetch_cnt  (fetch_cnt)
  );

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } item_t;

  item_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_acc = 0;
  int          phase = 0;
  logic [29:0] mpc = RST_PC;
  logic [31:0] exp_cnt = 32'd0;
  int          npc_mode = 0;
  logic [29:0] fixed_npc = 30'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: idle one cycle after reset, request until ack, hold until ready.
  always @(negedge clk) begin
    if (!rst) begin
      phase = 0;
      mpc = RST_PC;
      exp_cnt = 32'd0;
      exp_q.delete();
      chk("rst_pc", {2'b0, pc}, {2'b0, RST_PC});
      chk("rst_im_req", {31'd0, im_req}, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", {2'b0, inst_pc}, 32'd0);
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    end else begin
      chk("im_req", {31'd0, im_req}, {31'd0, phase == 1});
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, phase == 2});
      chk("pc", {2'b0, pc}, {2'b0, mpc});
      chk("fetch_cnt", fetch_cnt, exp_cnt);
      if (im_req) chk("im_addr", {2'b0, im_addr}, {2'b0, mpc});
      case (phase)
        0: phase = 1;
        1: if (im_ack) begin
             exp_q.push_back('{addr: mpc, data: im_rdata});
             phase = 2;
           end
        default: begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
          end else begin
            chk("inst", inst, exp_q[0].data);
            chk("inst_pc", {2'b0, inst_pc}, {2'b0, exp_q[0].addr});
            if (inst_ready) begin
              void'(exp_q.pop_front());
              mpc = npc;
              exp_cnt = exp_cnt + 32'd1;
              n_acc++;
              phase = 1;
            end
          end
        end
      endcase
    end
  end

  task automatic drive_cycle(input logic ack, input logic rdy);
    im_ack = ack;
    inst_ready = rdy;
    im_rdata = $urandom;
    case (npc_mode)
      0:       npc = mpc + 30'd1;
      1:       npc = fixed_npc;
      default: npc = 30'($urandom);
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic accept_one();
    int start;
    start = n_acc;
    for (int i = 0; i < 10 && n_acc == start; i++) drive_cycle(1'b1, 1'b1);
    chk("accept_timeout", {31'd0, n_acc != start}, 32'd1);
  endtask

  task automatic wait_valid_hold();
    for (int i = 0; i < 10 && !inst_valid; i++) drive_cycle(1'b1, 1'b0);
    chk("valid_timeout", {31'd0, inst_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    im_ack = 1'b0;
    im_rdata = 32'd0;
    inst_ready = 1'b0;
    npc = 30'd0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming with ack during the idle cycle, sequential npc
    npc_mode = 0;
    repeat (8) drive_cycle(1'b1, 1'b1);

    // Delayed ack
    repeat (4) drive_cycle(1'b0, 1'b1);
    repeat (3) drive_cycle(1'b1, 1'b1);

    // Consumer stall with npc toggling
    wait_valid_hold();
    npc_mode = 2;
    repeat (5) drive_cycle(1'b1, 1'b0);
    npc_mode = 0;
    accept_one();

    // Jump then wrap through the top of the address space
    npc_mode = 1;
    fixed_npc = 30'h0000_0C40;
    accept_one();
    npc_mode = 0;
    accept_one();
    npc_mode = 1;
    fixed_npc = 30'h3FFF_FFFF;
    accept_one();
    npc_mode = 0;
    accept_one();
    accept_one();

    // Reset while a request is outstanding
    for (int i = 0; i < 10 && !im_req; i++) drive_cycle(1'b0, 1'b1);
    chk("req_timeout", {31'd0, im_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_pc", {2'b0, pc}, {2'b0, RST_PC});
    chk("async_im_req", {31'd0, im_req}, 32'd0);
    chk("async_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_inst_pc", {2'b0, inst_pc}, 32'd0);
    chk("async_fetch_cnt", fetch_cnt, 32'd0);
    repeat (2) drive_cycle(1'b1, 1'b1);
    rst = 1'b1;
    repeat (6) drive_cycle(1'b1, 1'b1);

    // Counter wrap
    wait_valid_hold();
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    release dut.fetch_cnt;
    exp_cnt = 32'hFFFF_FFFF;
    drive_cycle(1'b1, 1'b0);
    accept_one();
    drive_cycle(1'b0, 1'b0);
    chk("fetch_cnt_wrap", fetch_cnt, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      npc_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
